sccomp: RTL and testbench

Minimal pipelined MIPS computer: a five-stage CPU core, a word-addressed instruction ROM and a data RAM, all in one clock domain. It is the top of the processor design; the only external observation port is a debug register-file read. Programs are preloaded into the instruction ROM by the simulation environment before reset is released.

---
 rtl/sccomp_pkg.sv | 121 ++++++++++++
 rtl/sccomp_cpu.sv | 152 +++++++++++++++
 rtl/sccomp_im.sv | 11 +
 rtl/sccomp_rf.sv | 32 +++
 rtl/sccomp.sv | 45 ++++
 tb/tb_sccomp.sv | 214 +++++++++++++++++++++
 6 files changed

// File: rtl/sccomp_pkg.sv
// Shared definitions for the sccomp pipelined MIPS subset: opcodes, ALU encoding,
// pipeline-register bundles and the instruction decoder.
package sccomp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] dest;
    logic       jump;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  dest;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu;
    logic [31:0] mem_data;
    logic [4:0]  dest;
  } mem_wb_t;

  // Unsupported encodings fall through with all controls low, i.e. a nop.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[31:26])
      OP_RTYPE: begin
        d.ctrl.reg_write = 1'b1;
        d.dest           = ins[15:11];
        case (ins[5:0])
          FN_ADD:  d.ctrl.alu_op = ALU_ADD;
          FN_SUB:  d.ctrl.alu_op = ALU_SUB;
          FN_AND:  d.ctrl.alu_op = ALU_AND;
          FN_OR:   d.ctrl.alu_op = ALU_OR;
          FN_SLT:  d.ctrl.alu_op = ALU_SLT;
          default: begin
            d.ctrl.reg_write = 1'b0;
            d.dest           = '0;
          end
        endcase
      end
      OP_ADDI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.dest           = ins[20:16];
      end
      OP_LW: begin
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.dest            = ins[20:16];
      end
      OP_SW: begin
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = ALU_SUB;
      end
      OP_J:    d.jump = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sccomp_cpu.sv
// Five-stage pipeline core with forwarding, load-use stall, beq in EX and j in ID.
module sccomp_cpu
  import sccomp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  if_id_t  if_id;
  id_ex_t  id_ex, id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;

  logic [31:0] pc4;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_a, id_b, id_imm, j_target;
  dec_t        id_dec;
  logic        load_use;
  logic [31:0] wb_data;
  logic [31:0] fwd_a, fwd_b, alu_b, ex_alu, br_target;
  logic        br_taken;

  assign pc4 = PC + 32'd4;

  assign id_rs    = if_id.instr[25:21];
  assign id_rt    = if_id.instr[20:16];
  assign id_dec   = decode(if_id.instr);
  assign id_imm   = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
  assign j_target = {if_id.pc4[31:28], if_id.instr[25:0], 2'b00};
  assign load_use = id_ex.ctrl.mem_read && (id_ex.rt == id_rs || id_ex.rt == id_rt);

  assign wb_data = mem_wb.mem_to_reg ? mem_wb.mem_data : mem_wb.alu;

  sccomp_rf U_RF (
    .clk      (clk),
    .rstn     (rstn),
    .ra1      (id_rs),
    .ra2      (id_rt),
    .rd1      (id_a),
    .rd2      (id_b),
    .we       (mem_wb.reg_write),
    .wa       (mem_wb.dest),
    .wd       (wb_data),
    .dbg_sel  (reg_sel),
    .dbg_data (reg_data)
  );

  always_comb begin
    id_ex_d      = '0;
    id_ex_d.ctrl = id_dec.ctrl;
    id_ex_d.pc4  = if_id.pc4;
    id_ex_d.a    = id_a;
    id_ex_d.b    = id_b;
    id_ex_d.imm  = id_imm;
    id_ex_d.rs   = id_rs;
    id_ex_d.rt   = id_rt;
    id_ex_d.dest = id_dec.dest;
  end

  // EX/MEM wins over MEM/WB; $0 is never a forwarding source.
  always_comb begin
    fwd_a = id_ex.a;
    if (ex_mem.reg_write && ex_mem.dest != 5'd0 && ex_mem.dest == id_ex.rs)
      fwd_a = ex_mem.alu;
    else if (mem_wb.reg_write && mem_wb.dest != 5'd0 && mem_wb.dest == id_ex.rs)
      fwd_a = wb_data;

    fwd_b = id_ex.b;
    if (ex_mem.reg_write && ex_mem.dest != 5'd0 && ex_mem.dest == id_ex.rt)
      fwd_b = ex_mem.alu;
    else if (mem_wb.reg_write && mem_wb.dest != 5'd0 && mem_wb.dest == id_ex.rt)
      fwd_b = wb_data;
  end

  assign alu_b = id_ex.ctrl.alu_src ? id_ex.imm : fwd_b;

  always_comb begin
    case (id_ex.ctrl.alu_op)
      ALU_ADD: ex_alu = fwd_a + alu_b;
      ALU_SUB: ex_alu = fwd_a - alu_b;
      ALU_AND: ex_alu = fwd_a & alu_b;
      ALU_OR:  ex_alu = fwd_a | alu_b;
      ALU_SLT: ex_alu = ($signed(fwd_a) < $signed(alu_b)) ? 32'd1 : '0;
      default: ex_alu = '0;
    endcase
  end

  assign br_taken  = id_ex.ctrl.branch && (fwd_a == fwd_b);
  assign br_target = id_ex.pc4 + {id_ex.imm[29:0], 2'b00};

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex.ctrl.reg_write;
    ex_mem_d.mem_to_reg = id_ex.ctrl.mem_to_reg;
    ex_mem_d.mem_write  = id_ex.ctrl.mem_write;
    ex_mem_d.alu        = ex_alu;
    ex_mem_d.store      = fwd_b;
    ex_mem_d.dest       = id_ex.dest;
  end

  assign dm_addr  = ex_mem.alu[8:2];
  assign dm_wdata = ex_mem.store;
  assign dm_we    = ex_mem.mem_write;

  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.reg_write  = ex_mem.reg_write;
    mem_wb_d.mem_to_reg = ex_mem.mem_to_reg;
    mem_wb_d.alu        = ex_mem.alu;
    mem_wb_d.mem_data   = dm_rdata;
    mem_wb_d.dest       = ex_mem.dest;
  end

  // Priority: taken beq (older) over j over load-use stall; redirects discard the stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      PC     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
      if (br_taken) begin
        PC    <= br_target;
        if_id <= '0;
        id_ex <= '0;
      end else if (id_dec.jump) begin
        PC    <= j_target;
        if_id <= '0;
        id_ex <= id_ex_d;
      end else if (load_use) begin
        id_ex <= '0;
      end else begin
        PC          <= pc4;
        if_id.pc4   <= pc4;
        if_id.instr <= instr;
        id_ex       <= id_ex_d;
      end
    end
  end

endmodule

// File: rtl/sccomp_im.sv
// Word-addressed instruction ROM; contents are preloaded by the environment.
module sccomp_im (
  input  logic [6:0]  addr,
  output logic [31:0] data
);

  logic [31:0] ROM [0:127];

  assign data = ROM[addr];

endmodule

// File: rtl/sccomp_rf.sv
// 32x32 register file: two bypassed read ports, one write port, and a debug read.
module sccomp_rf (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && wa != 5'd0) begin
      rf[wa] <= wd;
    end
  end

  // Same-cycle write is visible to ID reads so WB needs no separate forward path.
  assign rd1 = (ra1 == 5'd0) ? '0 : ((we && wa == ra1) ? wd : rf[ra1]);
  assign rd2 = (ra2 == 5'd0) ? '0 : ((we && wa == ra2) ? wd : rf[ra2]);

  assign dbg_data = (dbg_sel == 5'd0) ? '0 : rf[dbg_sel];

endmodule

// File: rtl/sccomp.sv
// sccomp top: pipelined core, instruction ROM and data RAM with a debug GPR read.
module sccomp
  import sccomp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  logic [31:0] PC;
  logic [31:0] instr;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_we;
  logic [31:0] dm [0:127];
  logic        unused_pc_bits;

  sccomp_im U_IM (
    .addr (PC[8:2]),
    .data (instr)
  );

  sccomp_cpu U_SCPU (
    .clk      (clk),
    .rstn     (rstn),
    .instr    (instr),
    .PC       (PC),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always_ff @(posedge clk) begin
    if (rstn && dm_we) dm[dm_addr] <= dm_wdata;
  end

  assign dm_rdata = dm[dm_addr];

  assign unused_pc_bits = ^{PC[31:9], PC[1:0]};

endmodule

// File: tb/tb_sccomp.sv
// Scoreboard bench for sccomp: directed programs, expectations queued, monitor compares.
module tb_sccomp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = '0;
  logic [31:0] reg_data;

  sccomp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_pc;
    logic [4:0]  sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Monitor: the debug read port (or PC net) is presented each cycle; sample mid-cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = e.is_pc ? dut.PC : reg_data;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: actual=%08h required=%08h (sel=%0d)", e.name, act, e.exp, e.sel);
        end
      end
    end
  end

  function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Queue one expectation for the current cycle, wait for the monitor, then advance one edge.
  task automatic expect_val(input string nm, input logic is_pc, input logic [4:0] sel,
                            input logic [31:0] v);
    exp_t e;
    reg_sel = sel;
    e.name  = nm;
    e.is_pc = is_pc;
    e.sel   = sel;
    e.exp   = v;
    exp_q.push_back(e);
    for (int t = 0; t < 4 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=no_sample required=%08h", nm, v);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reg(input string nm, input logic [4:0] sel, input logic [31:0] v);
    expect_val(nm, 1'b0, sel, v);
  endtask

  task automatic expect_pc(input string nm, input logic [31:0] v);
    expect_val(nm, 1'b1, 5'd0, v);
  endtask

  initial begin
    // ALU coverage: signed slt, sub wrap, and/or, unsupported opcode
    clear_rom();
    dut.U_IM.ROM[0] = i_op(6'h08, 5'd1, 5'd0, 16'hFFFD);
    dut.U_IM.ROM[1] = i_op(6'h08, 5'd2, 5'd0, 16'd5);
    dut.U_IM.ROM[2] = r_op(6'h2A, 5'd3, 5'd1, 5'd2);
    dut.U_IM.ROM[3] = r_op(6'h2A, 5'd4, 5'd2, 5'd1);
    dut.U_IM.ROM[4] = r_op(6'h22, 5'd5, 5'd1, 5'd2);
    dut.U_IM.ROM[5] = r_op(6'h24, 5'd6, 5'd1, 5'd2);
    dut.U_IM.ROM[6] = r_op(6'h25, 5'd7, 5'd1, 5'd2);
    dut.U_IM.ROM[7] = 32'h3C08_0123;
    do_reset();
    expect_pc("reset_pc", 32'h0);
    tick(20);
    expect_reg("slt_neg_lt_pos", 5'd3, 32'h0000_0001);
    expect_reg("slt_pos_lt_neg", 5'd4, 32'h0000_0000);
    expect_reg("sub_wrap", 5'd5, 32'hFFFF_FFF8);
    expect_reg("and", 5'd6, 32'h0000_0005);
    expect_reg("or", 5'd7, 32'hFFFF_FFFD);
    expect_reg("unsupported_nop", 5'd8, 32'h0000_0000);

    // Forwarding, store/load through DM, single load-use stall
    clear_rom();
    dut.U_IM.ROM[0] = i_op(6'h08, 5'd1, 5'd0, 16'd5);
    dut.U_IM.ROM[1] = i_op(6'h08, 5'd2, 5'd0, 16'd7);
    dut.U_IM.ROM[2] = r_op(6'h20, 5'd3, 5'd1, 5'd2);
    dut.U_IM.ROM[3] = i_op(6'h2B, 5'd3, 5'd0, 16'd4);
    dut.U_IM.ROM[4] = i_op(6'h23, 5'd4, 5'd0, 16'd4);
    dut.U_IM.ROM[5] = r_op(6'h20, 5'd5, 5'd4, 5'd4);
    do_reset();
    expect_pc("reset_pc2", 32'h0);
    expect_reg("reset_gpr3", 5'd3, 32'h0);
    tick(8);
    expect_reg("stall_not_early", 5'd5, 32'h0);
    expect_reg("stall_one_cycle", 5'd5, 32'h0000_0018);
    expect_reg("fwd_add", 5'd3, 32'h0000_000C);
    expect_reg("lw_data", 5'd4, 32'h0000_000C);
    expect_reg("addi1", 5'd1, 32'h0000_0005);
    expect_reg("addi2", 5'd2, 32'h0000_0007);

    // Taken beq flushes the two following instructions
    clear_rom();
    dut.U_IM.ROM[0] = i_op(6'h08, 5'd1, 5'd0, 16'd1);
    dut.U_IM.ROM[1] = i_op(6'h04, 5'd1, 5'd1, 16'd2);
    dut.U_IM.ROM[2] = i_op(6'h08, 5'd6, 5'd0, 16'd1);
    dut.U_IM.ROM[3] = i_op(6'h08, 5'd6, 5'd0, 16'd2);
    dut.U_IM.ROM[4] = i_op(6'h08, 5'd8, 5'd0, 16'd9);
    do_reset();
    tick(20);
    expect_reg("beq_flushed", 5'd6, 32'h0);
    expect_reg("beq_target", 5'd8, 32'h0000_0009);

    // Countdown loop with beq exit and j back-edge
    clear_rom();
    dut.U_IM.ROM[0] = i_op(6'h08, 5'd7, 5'd0, 16'd3);
    dut.U_IM.ROM[1] = i_op(6'h08, 5'd9, 5'd0, 16'd0);
    dut.U_IM.ROM[2] = i_op(6'h04, 5'd0, 5'd7, 16'd3);
    dut.U_IM.ROM[3] = i_op(6'h08, 5'd7, 5'd7, 16'hFFFF);
    dut.U_IM.ROM[4] = i_op(6'h08, 5'd9, 5'd9, 16'd1);
    dut.U_IM.ROM[5] = j_op(26'd2);
    dut.U_IM.ROM[6] = i_op(6'h08, 5'd10, 5'd0, 16'h0055);
    do_reset();
    tick(80);
    expect_reg("loop_counter", 5'd7, 32'h0);
    expect_reg("loop_count", 5'd9, 32'h0000_0003);
    expect_reg("loop_exit", 5'd10, 32'h0000_0055);

    // j to 0x40 flushes the delay-slot fetch
    clear_rom();
    dut.U_IM.ROM[0]  = j_op(26'h10);
    dut.U_IM.ROM[1]  = i_op(6'h08, 5'd11, 5'd0, 16'd1);
    dut.U_IM.ROM[16] = i_op(6'h08, 5'd12, 5'd0, 16'd2);
    do_reset();
    tick(2);
    expect_pc("j_pc", 32'h0000_0040);
    tick(10);
    expect_reg("j_flushed", 5'd11, 32'h0);
    expect_reg("j_target", 5'd12, 32'h0000_0002);

    // $0 stays zero; mid-run reset restarts at PC 0 with cleared GPRs
    clear_rom();
    dut.U_IM.ROM[0] = i_op(6'h08, 5'd0, 5'd0, 16'd9);
    dut.U_IM.ROM[1] = i_op(6'h08, 5'd13, 5'd0, 16'd7);
    do_reset();
    tick(10);
    expect_reg("r0_zero", 5'd0, 32'h0);
    expect_reg("r13_before", 5'd13, 32'h0000_0007);
    do_reset();
    expect_pc("midrun_reset_pc", 32'h0);
    expect_reg("midrun_reset_gpr", 5'd13, 32'h0);
    tick(10);
    expect_reg("r13_after", 5'd13, 32'h0000_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
